// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command queue: field widths, packed command
// layout and dispatcher state encoding.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CMD_W  = 1 + ADDR_W + DATA_W;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_RESP      = 2'd3;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/i2c_cmd_queue_if.sv
// Bundle of the producer, response and I2C-master-facing signals of the queue.
interface i2c_cmd_queue_if #(
  parameter int unsigned DEPTH = 4
);
  import i2c_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_ack_err;
  logic              rsp_timeout;

  logic [CNT_W-1:0]  pending;

  logic              m_start;
  logic              m_wr;
  logic [ADDR_W-1:0] m_slave_addr;
  logic [DATA_W-1:0] m_data_in;
  logic              m_busy;
  logic              m_ack_error;
  logic [DATA_W-1:0] m_data_out;

  // Queue side
  modport slave (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready,
           m_busy, m_ack_error, m_data_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_ack_err, rsp_timeout,
           pending, m_start, m_wr, m_slave_addr, m_data_in
  );

  // Producer / consumer / master side
  modport master (
    output cmd_valid, cmd_wr, cmd_addr, cmd_data, rsp_ready,
           m_busy, m_ack_error, m_data_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ack_err, rsp_timeout,
           pending, m_start, m_wr, m_slave_addr, m_data_in
  );

endinterface

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with occupancy count and first-word-fall-through read data.
module i2c_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/i2c_cmd_queue.sv
// Buffers single-byte I2C commands and dispatches them one at a time to the
// master, returning one response (data / NACK / launch timeout) per command.
module i2c_cmd_queue
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned START_TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst,
  i2c_cmd_queue_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned TMR_W = $clog2(START_TIMEOUT);

  logic [1:0]        state_q,       state_d;
  logic [TMR_W-1:0]  timer_q,       timer_d;
  logic              m_start_q,     m_start_d;
  cmd_t              m_cmd_q,       m_cmd_d;
  logic              rsp_valid_q,   rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,    rsp_data_d;
  logic              rsp_ack_err_q, rsp_ack_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  cmd_t              push_cmd;
  logic [CMD_W-1:0]  head_raw;
  cmd_t              head;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  assign push_cmd = '{wr: bus.cmd_wr, addr: bus.cmd_addr, data: bus.cmd_data};
  assign push     = bus.cmd_valid && !full;
  assign pop      = (state_q == ST_IDLE) && !empty && !bus.m_busy;
  assign head     = cmd_t'(head_raw);

  i2c_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (CMD_W'(push_cmd)),
    .rdata_o (head_raw),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      m_start_q     <= 1'b0;
      m_cmd_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_ack_err_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      m_start_q     <= m_start_d;
      m_cmd_q       <= m_cmd_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_ack_err_q <= rsp_ack_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Dispatcher: launch, wait for busy envelope, capture result, hold response
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    m_start_d     = 1'b0;
    m_cmd_d       = m_cmd_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_ack_err_d = rsp_ack_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          m_start_d = 1'b1;
          m_cmd_d   = head;
          timer_d   = '0;
          state_d   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        timer_d = timer_q + TMR_W'(1);
        if (bus.m_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TMR_W'(START_TIMEOUT - 1)) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_ack_err_d = 1'b0;
          rsp_data_d    = '0;
          state_d       = ST_RESP;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.m_busy) begin
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b0;
          rsp_ack_err_d = bus.m_ack_error;
          rsp_data_d    = m_cmd_q.wr ? '0 : bus.m_data_out;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.cmd_ready    = !full;
  assign bus.pending      = count;
  assign bus.m_start      = m_start_q;
  assign bus.m_wr         = m_cmd_q.wr;
  assign bus.m_slave_addr = m_cmd_q.addr;
  assign bus.m_data_in    = m_cmd_q.data;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_ack_err  = rsp_ack_err_q;
  assign bus.rsp_timeout  = rsp_timeout_q;

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Bench for i2c_cmd_queue: behavioural master, transaction-level scoreboard
// checked every cycle, and directed scenarios with literal expectations.
module tb_i2c_cmd_queue;
  import i2c_pkg::*;

  localparam int DEPTH = 4;
  localparam int START_TIMEOUT = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       ack;
    logic       to;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_cmd_queue_if #(.DEPTH(DEPTH)) bus ();

  i2c_cmd_queue #(
    .DEPTH         (DEPTH),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Master behaviour knobs
  logic       mst_busy = 1'b0;
  logic       force_busy = 1'b0;
  bit         mst_never = 1'b0;
  int         mst_len = 20;
  logic [7:0] mst_rdata = 8'h00;
  logic       mst_ack = 1'b0;
  assign bus.m_busy = mst_busy | force_busy;

  int   n_cmp = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;
  int   cyc = 0;
  int   n_start = 0;
  int   n_rsp = 0;
  int   acc_cyc = 0;
  int   start_cyc = 0;
  int   fall_cyc = -1;
  int   free_cyc = 0;
  int   last_rsp_cyc = 0;
  cmd_t st_cmd;
  rsp_t last_rsp;

  cmd_t acc_q[$];
  rsp_t exp_q[$];
  cmd_t cur;
  cmd_t acc_cmd;
  bit   acc_pend = 1'b0;
  bit   inflight = 1'b0;
  bit   saw_busy = 1'b0;
  bit   rsp_seen = 1'b0;
  rsp_t rsp_hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic expire(input string name, input int waited);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing after %0d cycles", name, waited);
  endtask

  // Master: goes busy the cycle after it sees m_start, result valid as busy drops
  initial begin
    bus.m_data_out  = 8'h00;
    bus.m_ack_error = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.m_start && !mst_never) begin
        @(posedge clk); #1;
        mst_busy        = 1'b1;
        bus.m_data_out  = ~mst_rdata;
        bus.m_ack_error = ~mst_ack;
        repeat (mst_len) @(posedge clk);
        #1;
        mst_busy        = 1'b0;
        bus.m_data_out  = mst_rdata;
        bus.m_ack_error = mst_ack;
      end
    end
  end

  // Scoreboard: FIFO order, one command in flight, response content and timing
  always @(negedge clk) begin : cmp
    rsp_t e;
    rsp_t now;
    cyc++;
    if (chk_en) begin
      if (acc_pend) begin
        acc_q.push_back(acc_cmd);
        acc_pend = 1'b0;
      end
      if (bus.m_start) begin
        n_start++;
        chk("start_gap", 32'(inflight || (cyc < free_cyc)), 32'(0));
        if (acc_q.size() == 0) begin
          expire("start_without_cmd", 0);
        end else begin
          cur = acc_q.pop_front();
          chk("start_fields", 32'({bus.m_wr, bus.m_slave_addr, bus.m_data_in}), 32'(cur));
          e.to   = mst_never;
          e.ack  = mst_never ? 1'b0 : mst_ack;
          e.data = (mst_never || cur.wr) ? 8'h00 : mst_rdata;
          exp_q.push_back(e);
          inflight  = 1'b1;
          saw_busy  = 1'b0;
          fall_cyc  = -1;
          start_cyc = cyc;
          st_cmd    = cur;
        end
      end else if (inflight) begin
        chk("m_fields_hold", 32'({bus.m_wr, bus.m_slave_addr, bus.m_data_in}), 32'(cur));
      end
      chk("pending", 32'(bus.pending), 32'(acc_q.size()));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(acc_q.size() != DEPTH));
      if (inflight && saw_busy && !bus.m_busy && fall_cyc < 0) fall_cyc = cyc;
      if (inflight && bus.m_busy) saw_busy = 1'b1;
      now = '{data: bus.rsp_data, ack: bus.rsp_ack_err, to: bus.rsp_timeout};
      if (bus.rsp_valid) begin
        if (!rsp_seen) begin
          n_rsp++;
          if (!inflight || exp_q.size() == 0) begin
            expire("unexpected_rsp", 0);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_content", 32'(now), 32'(e));
            if (e.to) chk("timeout_latency", 32'(cyc - start_cyc), 32'(START_TIMEOUT));
            else      chk("done_latency", 32'(cyc - fall_cyc), 32'(1));
          end
          rsp_seen     = 1'b1;
          rsp_hold     = now;
          last_rsp     = now;
          last_rsp_cyc = cyc;
        end else begin
          chk("rsp_hold", 32'(now), 32'(rsp_hold));
        end
        if (bus.rsp_ready) begin
          rsp_seen = 1'b0;
          inflight = 1'b0;
          free_cyc = cyc + 2;
        end
      end
      if (bus.cmd_valid && bus.cmd_ready && !rst) begin
        acc_pend = 1'b1;
        acc_cmd  = '{wr: bus.cmd_wr, addr: bus.cmd_addr, data: bus.cmd_data};
        acc_cyc  = cyc;
      end
      if (rst) begin
        acc_q.delete();
        exp_q.delete();
        inflight = 1'b0;
        rsp_seen = 1'b0;
        acc_pend = 1'b0;
      end
    end
  end

  task automatic push(input logic wr, input logic [6:0] a, input logic [7:0] d);
    int  n = 0;
    bit  done = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = a;
    bus.cmd_data  = d;
    while (!done) begin
      @(negedge clk);
      if (bus.cmd_ready) done = 1'b1;
      else if (++n > 100) begin
        expire("push_accept", n);
        done = 1'b1;
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_starts(input int target, input int budget);
    int k = 0;
    while (n_start < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (n_start < target) expire("wait_start", k);
  endtask

  task automatic wait_rsps(input int target, input int budget);
    int k = 0;
    while (n_rsp < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (n_rsp < target) expire("wait_rsp", k);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pending"},   32'(bus.pending), 32'(0));
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'(1));
    chk({tag, "_m_start"},   32'(bus.m_start), 32'(0));
    chk({tag, "_m_fields"},  32'({bus.m_wr, bus.m_slave_addr, bus.m_data_in}), 32'(0));
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    chk({tag, "_rsp_fields"}, 32'({bus.rsp_data, bus.rsp_ack_err, bus.rsp_timeout}), 32'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int s0;
    int r0;
    int fall;
    bus.cmd_valid = 1'b0;
    bus.cmd_wr    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset values
    @(posedge clk);
    @(negedge clk); #1;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    bus.rsp_ready = 1'b1;

    // Write 0x50 / 0xA5, 20-cycle busy, ACK
    mst_len = 20; mst_ack = 1'b0; mst_rdata = 8'h77;
    push(1'b1, 7'h50, 8'hA5);
    wait_starts(1, 20);
    chk("t1_start_latency", 32'(start_cyc - acc_cyc), 32'(2));
    chk("t1_start_cmd", 32'(st_cmd), 32'({1'b1, 7'h50, 8'hA5}));
    wait_rsps(1, 80);
    chk("t1_rsp", 32'(last_rsp), 32'({8'h00, 1'b0, 1'b0}));

    // Read 0x68 returning 0x3C with NACK
    mst_len = 6; mst_ack = 1'b1; mst_rdata = 8'h3C;
    push(1'b0, 7'h68, 8'h00);
    wait_rsps(2, 80);
    chk("t2_rsp", 32'(last_rsp), 32'({8'h3C, 1'b1, 1'b0}));

    // Back-pressure: five commands against a 4-deep queue
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    force_busy = 1'b1;
    mst_len = 3; mst_ack = 1'b0; mst_rdata = 8'h5A;
    s0 = n_start;
    r0 = n_rsp;
    fork
      begin
        push(1'b1, 7'h10, 8'h01);
        push(1'b0, 7'h11, 8'h02);
        push(1'b1, 7'h12, 8'h03);
        push(1'b0, 7'h13, 8'h04);
        push(1'b0, 7'h14, 8'h05);
      end
      begin
        int k = 0;
        while (bus.pending != 3'd4 && k < 60) begin
          @(negedge clk); #1;
          k++;
        end
        repeat (3) begin
          @(negedge clk); #1;
          chk("t3_full_ready", 32'(bus.cmd_ready), 32'(0));
          chk("t3_full_pending", 32'(bus.pending), 32'(4));
        end
        @(posedge clk); #1;
        force_busy = 1'b0;
      end
    join
    wait_starts(s0 + 1, 20);
    repeat (30) @(posedge clk);
    chk("t3_single_start", 32'(n_start), 32'(s0 + 1));
    chk("t3_rsp_held", 32'(bus.rsp_valid), 32'(1));
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_rsps(r0 + 5, 300);
    chk("t3_last_rsp", 32'(last_rsp), 32'({8'h5A, 1'b0, 1'b0}));
    chk("t3_total_starts", 32'(n_start), 32'(s0 + 5));

    // Launch timeout, second command waits for the response to be taken
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    mst_never = 1'b1;
    s0 = n_start;
    r0 = n_rsp;
    push(1'b0, 7'h22, 8'h00);
    push(1'b1, 7'h23, 8'h99);
    wait_rsps(r0 + 1, 60);
    chk("t4_timeout_latency", 32'(last_rsp_cyc - start_cyc), 32'(16));
    chk("t4_timeout_rsp", 32'(last_rsp), 32'({8'h00, 1'b0, 1'b1}));
    repeat (5) @(posedge clk);
    chk("t4_stalled", 32'(n_start), 32'(s0 + 1));
    #1;
    mst_never = 1'b0;
    mst_len = 4;
    bus.rsp_ready = 1'b1;
    wait_rsps(r0 + 2, 60);
    chk("t4_second_rsp", 32'(last_rsp), 32'({8'h00, 1'b0, 1'b0}));

    // Master already busy before the push
    @(posedge clk); #1;
    force_busy = 1'b1;
    s0 = n_start;
    push(1'b1, 7'h31, 8'h42);
    repeat (6) @(posedge clk);
    chk("t5_no_start_while_busy", 32'(n_start), 32'(s0));
    #1;
    force_busy = 1'b0;
    @(negedge clk); #1;
    fall = cyc;
    wait_starts(s0 + 1, 20);
    chk("t5_start_after_fall", 32'(start_cyc - fall), 32'(1));
    wait_rsps(n_rsp + 1, 60);

    // Reset during WAIT_DONE with two commands queued
    mst_len = 40;
    s0 = n_start;
    push(1'b0, 7'h40, 8'h00);
    wait_starts(s0 + 1, 20);
    repeat (4) @(posedge clk);
    push(1'b1, 7'h41, 8'h11);
    push(1'b0, 7'h42, 8'h00);
    chk("t6_pre_reset_pending", 32'(bus.pending), 32'(2));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    chk("t6_pre_reset_addr", 32'(bus.m_slave_addr), 32'(7'h40));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk_reset_outputs("t6_reset");
    r0 = n_rsp;
    repeat (80) @(posedge clk);
    chk("t6_no_rsp", 32'(n_rsp), 32'(r0));
    chk("t6_no_start", 32'(n_start), 32'(s0 + 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
